// File: rtl/aes_host_ctrl.sv
// Byte-serial host wrapper for an AES core: collects 16 plaintext bytes, loads the core, then drains
// 16 ciphertext bytes under valid/ready backpressure. Optional WAIT timeout with sticky err: AES_TIMEOUT_EN.
module aes_host_ctrl #(
  parameter int TIMEOUT_CYC = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  input  logic [127:0] key_cfg,
  output logic         aes_ld,
  output logic [127:0] aes_key,
  output logic [127:0] aes_text_in,
  input  logic         aes_done,
  input  logic [127:0] aes_text_out,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {COLLECT, LOAD, WAIT, DRAIN} state_t;

  state_t       state;
  logic [3:0]   cnt;
  logic [127:0] in_shift;
  logic [127:0] out_shift;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_data = out_shift[127:120];

`ifdef AES_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      cnt         <= 4'd0;
      in_shift    <= '0;
      out_shift   <= '0;
      aes_key     <= '0;
      aes_text_in <= '0;
      aes_ld      <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
`ifdef AES_TIMEOUT_EN
      tcnt        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      aes_ld <= 1'b0;
      case (state)
        COLLECT: begin
          if (in_fire) begin
            in_shift <= {in_shift[119:0], in_data};
            cnt      <= cnt + 4'd1;
            // Register the completed block directly so it is stable during LOAD.
            if (cnt == 4'd15) begin
              aes_text_in <= {in_shift[119:0], in_data};
              aes_key     <= key_cfg;
              aes_ld      <= 1'b1;
              in_ready    <= 1'b0;
              busy        <= 1'b1;
              state       <= LOAD;
            end
          end
        end
        LOAD: begin
          state <= WAIT;
`ifdef AES_TIMEOUT_EN
          tcnt  <= '0;
`endif
        end
        WAIT: begin
          if (aes_done) begin
            out_shift <= aes_text_out;
            out_valid <= 1'b1;
            state     <= DRAIN;
          end
`ifdef AES_TIMEOUT_EN
          // A done arriving on the expiry cycle takes priority over the abort.
          else if (tcnt == TW'(TIMEOUT_CYC)) begin
            err_q    <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            state    <= COLLECT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (out_fire) begin
            out_shift <= {out_shift[119:0], 8'h00};
            cnt       <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              out_valid <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
              state     <= COLLECT;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_ctrl.sv
// Bench for aes_host_ctrl: acts as host, downstream sink and a mock AES core; expected bytes come
// from the block values the bench itself chose, kept in a queue per block.
module tb_aes_host_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] key_cfg;
  logic         aes_ld;
  logic [127:0] aes_key;
  logic [127:0] aes_text_in;
  logic         aes_done;
  logic [127:0] aes_text_out;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic         busy;
  logic         err;

  int   n_cmp   = 0;
  int   n_err   = 0;
  int   ld_cnt  = 0;
  logic exp_err = 1'b0;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_host_ctrl #(.TIMEOUT_CYC(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .key_cfg(key_cfg), .aes_ld(aes_ld), .aes_key(aes_key), .aes_text_in(aes_text_in),
    .aes_done(aes_done), .aes_text_out(aes_text_out),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err)
  );

  always @(posedge clk) if (aes_ld === 1'b1) ld_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Mock cipher: any bijective-looking mix of key and text is enough to track byte order.
  function automatic logic [127:0] mock_core(input logic [127:0] key, input logic [127:0] pt);
    return pt ^ {key[63:0], key[127:64]} ^ 128'ha5c3_5a3c_0ff0_1234_8765_4321_dead_beef;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; aes_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_in_ready",  128'(in_ready), 128'd1);
    check("rst_aes_ld",    128'(aes_ld), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy), 128'd0);
    check("rst_err",       128'(err), 128'd0);
    check("rst_aes_key",   aes_key, 128'd0);
    check("rst_text_in",   aes_text_in, 128'd0);
    check("rst_out_data",  128'(out_data), 128'd0);
  endtask

  // Offer the first n bytes of pt, MSB first, with gap idle cycles before each one.
  task automatic send_bytes(input logic [127:0] pt, input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      repeat (gap) tick();
      in_valid = 1'b1;
      in_data  = pt[127-8*i -: 8];
      guard = 0;
      while (!in_ready && guard < 50) begin tick(); guard++; end
      check("in_ready_collect", 128'(in_ready), 128'd1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // mode: 0 ready always, 1 ready toggles each cycle, 2 random ready.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct,
                           input int gap, input int mode, input int stray, input int wait_cyc,
                           input int abort_at);
    logic [7:0] q[$];
    int ld0, got_n, guard;
    logic r, tg, strayed;
    ld0 = ld_cnt;
    key_cfg = key;
    send_bytes(pt, 16, gap);
    check("ld_after_16th", 128'(aes_ld), 128'd1);
    check("text_in_load", aes_text_in, pt);
    check("key_load", aes_key, key);
    check("in_ready_load", 128'(in_ready), 128'd0);
    check("busy_load", 128'(busy), 128'd1);
    key_cfg = ~key;
    tick();
    check("ld_single_cycle", 128'(aes_ld), 128'd0);
    repeat (wait_cyc) tick();
    check("wait_no_valid", 128'(out_valid), 128'd0);
    for (int i = 0; i < 16; i++) q.push_back(ct[127-8*i -: 8]);
    aes_done = 1'b1; aes_text_out = ct;
    tick();
    aes_done = 1'b0; aes_text_out = rand128();
    got_n = 0; guard = 0; tg = 1'b1; strayed = 1'b0;
    while (got_n < 16 && guard < 200) begin
      guard++;
      if (got_n == abort_at) break;
      case (mode)
        0:       r = 1'b1;
        1:       begin r = tg; tg = ~tg; end
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (got_n == stray && !strayed) begin
        r = 1'b0; aes_done = 1'b1; aes_text_out = rand128(); strayed = 1'b1;
      end
      out_ready = r;
      check("out_valid_drain", 128'(out_valid), 128'd1);
      check("out_data", 128'(out_data), 128'(q[0]));
      check("in_ready_drain", 128'(in_ready), 128'd0);
      tick();
      aes_done = 1'b0;
      if (r) begin void'(q.pop_front()); got_n++; end
    end
    out_ready = 1'b0;
    if (abort_at >= 0) return;
    check("drain_count", 128'(got_n), 128'd16);
    check("out_valid_end", 128'(out_valid), 128'd0);
    check("in_ready_end", 128'(in_ready), 128'd1);
    check("busy_end", 128'(busy), 128'd0);
    check("ld_per_block", 128'(ld_cnt - ld0), 128'd1);
    check("key_held", aes_key, key);
    check("text_in_held", aes_text_in, pt);
    check("err_level", 128'(err), 128'(exp_err));
  endtask

  initial begin
    logic [127:0] k, p;
    int cyc;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; key_cfg = '0;
    aes_done = 1'b0; aes_text_out = '0; out_ready = 1'b0;
    tick(); tick();
    do_reset();
    check_reset();

    // FIPS-197 known answer, core latency 3 cycles.
    run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, -1, 3, -1);

    // Downstream backpressure toggling every cycle.
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 1, -1, 1, -1);

    // Gapped input: valid one cycle out of three.
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 2, 0, -1, 0, -1);

    // Reset after 7 bytes, then a clean FIPS block.
    key_cfg = rand128();
    send_bytes(rand128(), 7, 0);
    do_reset();
    check_reset();
    run_block(FIPS_KEY, FIPS_PT, FIPS_CT, 0, 0, -1, 2, -1);

    // Stray done in COLLECT, then a block with a stray done mid-drain.
    aes_done = 1'b1; aes_text_out = rand128();
    tick(); tick();
    aes_done = 1'b0;
    check("stray_collect_in_ready", 128'(in_ready), 128'd1);
    check("stray_collect_valid", 128'(out_valid), 128'd0);
    check("stray_collect_busy", 128'(busy), 128'd0);
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 2, 5, 4, -1);

    // Reset during drain discards remaining output.
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 0, -1, 1, 4);
    do_reset();
    check_reset();
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 1, 2, -1, 2, -1);

`ifdef AES_TIMEOUT_EN
    // Done on the expiry cycle still delivers data.
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 0, -1, 32, -1);

    // No done: abort with sticky err.
    key_cfg = rand128();
    send_bytes(rand128(), 16, 0);
    tick();
    cyc = 0;
    while (err !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    check("timeout_err", 128'(err), 128'd1);
    check("timeout_cycles", 128'(cyc), 128'd33);
    check("timeout_no_valid", 128'(out_valid), 128'd0);
    check("timeout_in_ready", 128'(in_ready), 128'd1);
    exp_err = 1'b1;
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 1, -1, 2, -1);
    do_reset();
    exp_err = 1'b0;
    check_reset();
`else
    // Without the timeout, WAIT holds indefinitely.
    k = rand128(); p = rand128();
    run_block(k, p, mock_core(k, p), 0, 0, -1, 60, -1);
`endif

    // Random mix of gaps, backpressure and core latency.
    for (int n = 0; n < 4; n++) begin
      k = rand128(); p = rand128();
      run_block(k, p, mock_core(k, p), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                -1, int'($urandom_range(0, 6)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
